// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped table of {valid, tag, 2-bit counter, target}.
// Fetch lookups are combinational and always see the pre-update table. Resolved
// conditional branches train the table. A misprediction produces a registered
// one-cycle redirect pulse and bumps a saturating counter.
//
// Handshake: there is no back-pressure. i_fetch_valid qualifies the fetch lookup
// in the same cycle. i_res_valid qualifies the resolution bundle and is consumed
// on the rising edge where it is high. o_redirect is a valid-only pulse, and
// o_redirect_pc is meaningful only while o_redirect is high.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_fetch_valid,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_res_valid,
    input  logic            i_res_is_branch,
    input  logic [XLEN-1:0] i_res_pc,
    input  logic            i_res_taken,
    input  logic [XLEN-1:0] i_res_target,
    input  logic            i_res_pred_taken,
    input  logic [XLEN-1:0] i_res_pred_target,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [15:0]     o_mispredict_cnt
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = XLEN - IW - 2;

    // Table storage
    logic [ENTRIES-1:0] r_valid;
    logic [TW-1:0]      r_tag [ENTRIES];
    logic [1:0]         r_ctr [ENTRIES];
    logic [XLEN-1:0]    r_tgt [ENTRIES];

    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;
    logic [15:0]     r_mispredict_cnt;

    logic [IW-1:0] w_fetch_idx;
    logic [TW-1:0] w_fetch_tag;
    logic          w_fetch_hit;
    logic [IW-1:0] w_res_idx;
    logic [TW-1:0] w_res_tag;
    logic          w_res_hit;
    logic          w_update;
    logic          w_mispredict;
    logic [1:0]    w_ctr_next;
    logic [XLEN-1:0] w_redirect_pc_next;
    logic          w_unused_lsbs;

    // The low two PC bits never select or tag an entry.
    assign w_unused_lsbs = ^{i_fetch_pc[1:0], i_res_pc[1:0]};

    assign w_fetch_idx = i_fetch_pc[IW+1:2];
    assign w_fetch_tag = i_fetch_pc[XLEN-1:IW+2];
    assign w_res_idx   = i_res_pc[IW+1:2];
    assign w_res_tag   = i_res_pc[XLEN-1:IW+2];

    // Fetch-side lookup, reading current (pre-update) table contents
    always_comb begin
        w_fetch_hit   = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
        o_pred_taken  = i_fetch_valid && w_fetch_hit && r_ctr[w_fetch_idx][1];
        o_pred_target = o_pred_taken ? r_tgt[w_fetch_idx] : (i_fetch_pc + XLEN'(4));
    end

    // Resolution decode: hit detection, counter step, mispredict and redirect target
    always_comb begin
        w_update  = i_res_valid && i_res_is_branch;
        w_res_hit = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
        w_ctr_next = r_ctr[w_res_idx];
        if (i_res_taken) begin
            if (r_ctr[w_res_idx] != 2'b11) w_ctr_next = r_ctr[w_res_idx] + 2'd1;
        end else begin
            if (r_ctr[w_res_idx] != 2'b00) w_ctr_next = r_ctr[w_res_idx] - 2'd1;
        end
        w_mispredict = w_update &&
                       ((i_res_taken != i_res_pred_taken) ||
                        (i_res_taken && (i_res_target != i_res_pred_target)));
        w_redirect_pc_next = i_res_taken ? i_res_target : (i_res_pc + XLEN'(4));
    end

    // Table training: hits step the counter; taken misses allocate as weak-taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i] <= '0;
                r_ctr[i] <= 2'b01;
                r_tgt[i] <= '0;
            end
        end else if (w_update) begin
            if (w_res_hit) begin
                r_ctr[w_res_idx] <= w_ctr_next;
                if (i_res_taken) r_tgt[w_res_idx] <= i_res_target;
            end else if (i_res_taken) begin
                r_valid[w_res_idx] <= 1'b1;
                r_tag[w_res_idx]   <= w_res_tag;
                r_ctr[w_res_idx]   <= 2'b10;
                r_tgt[w_res_idx]   <= i_res_target;
            end
        end
    end

    // Redirect pulse and saturating mispredict count, one cycle after resolution
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect       <= 1'b0;
            r_redirect_pc    <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_redirect <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_redirect_pc_next;
                if (r_mispredict_cnt != 16'hFFFF) r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
            end
        end
    end

    assign o_redirect       = r_redirect;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver applies one resolution/fetch
// bundle per cycle and pushes expected results from a table-level model; a
// monitor on the falling edge pops and compares.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int XLEN    = 32;
  localparam int LOGE    = $clog2(ENTRIES);

  logic            clk;
  logic            rst_n;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            res_valid;
  logic            res_is_branch;
  logic [XLEN-1:0] res_pc;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_pred_taken;
  logic [XLEN-1:0] res_pred_target;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [15:0]     mispredict_cnt;

  branch_predictor #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_fetch_valid     (fetch_valid),
    .i_fetch_pc        (fetch_pc),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .i_res_valid       (res_valid),
    .i_res_is_branch   (res_is_branch),
    .i_res_pc          (res_pc),
    .i_res_taken       (res_taken),
    .i_res_target      (res_target),
    .i_res_pred_taken  (res_pred_taken),
    .i_res_pred_target (res_pred_target),
    .o_redirect        (redirect),
    .o_redirect_pc     (redirect_pc),
    .o_mispredict_cnt  (mispredict_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt;

  // scoreboard queues
  logic [32:0] exp_lk_q[$];   // {taken, target} for the current cycle
  logic [15:0] exp_cnt_q[$];  // count visible in the current cycle
  logic [63:0] exp_rd_q[$];   // {cycle of pulse, redirect pc}

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (LOGE + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
      m_tgt[i]   = 0;
    end
    m_cnt = 0;
    exp_rd_q.delete();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit fv, input logic [31:0] fpc,
                      input bit rv, input bit rb, input logic [31:0] rpc,
                      input bit rt, input logic [31:0] rtgt,
                      input bit rpt, input logic [31:0] rptgt);
    int  fi, ri;
    bit  hit, tk, mis;
    @(posedge clk);
    #1;
    rst_n           = 1'b1;
    fetch_valid     = fv;
    fetch_pc        = fpc;
    res_valid       = rv;
    res_is_branch   = rb;
    res_pc          = rpc;
    res_taken       = rt;
    res_target      = rtgt;
    res_pred_taken  = rpt;
    res_pred_target = rptgt;
    started         = 1;
    // expected lookup sees the table before this cycle's update
    fi  = idx_of(fpc);
    hit = m_valid[fi] && (m_tag[fi] == tag_of(fpc));
    tk  = fv && hit && (m_ctr[fi] >= 2);
    exp_lk_q.push_back({tk, tk ? m_tgt[fi] : fpc + 32'd4});
    exp_cnt_q.push_back(16'(m_cnt));
    if (rv && rb) begin
      mis = (rt != rpt) || (rt && (rtgt != rptgt));
      if (mis) begin
        exp_rd_q.push_back({32'(cyc + 1), rt ? rtgt : rpc + 32'd4});
        if (m_cnt < 65535) m_cnt++;
      end
      ri = idx_of(rpc);
      if (m_valid[ri] && (m_tag[ri] == tag_of(rpc))) begin
        m_ctr[ri] = rt ? ((m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1)
                       : ((m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1);
        if (rt) m_tgt[ri] = rtgt;
      end else if (rt) begin
        m_valid[ri] = 1;
        m_tag[ri]   = tag_of(rpc);
        m_ctr[ri]   = 2;
        m_tgt[ri]   = rtgt;
      end
    end
  endtask

  task automatic fetch_only(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset with a live resolution on the bus; it must be discarded.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n           = 1'b0;
      fetch_valid     = 1'b1;
      fetch_pc        = 32'h100 + 32'($urandom_range(0, 63) << 2);
      res_valid       = 1'b1;
      res_is_branch   = 1'b1;
      res_pc          = 32'h100;
      res_taken       = 1'b1;
      res_target      = 32'h0BAD_0000;
      res_pred_taken  = 1'b0;
      res_pred_target = 32'h0;
      model_reset();
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_redirect", {63'd0, redirect}, 64'd0);
      chk("rst_redirect_pc", {32'd0, redirect_pc}, 64'd0);
      chk("rst_cnt", {48'd0, mispredict_cnt}, 64'd0);
      chk("rst_lookup", {31'd0, pred_taken, pred_target}, {31'd0, 1'b0, fetch_pc + 32'd4});
    end else if (started) begin
      bit exp_now;
      if (exp_lk_q.size() == 0) begin
        chk("lookup_queue_empty", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_lk_q.pop_front();
        chk("lookup", {31'd0, pred_taken, pred_target}, {31'd0, e});
      end
      if (exp_cnt_q.size() == 0) begin
        chk("cnt_queue_empty", 64'd1, 64'd0);
      end else begin
        logic [15:0] c;
        c = exp_cnt_q.pop_front();
        chk("mispredict_cnt", {48'd0, mispredict_cnt}, {48'd0, c});
      end
      exp_now = (exp_rd_q.size() > 0) && (exp_rd_q[0][63:32] == 32'(cyc));
      chk("redirect", {63'd0, redirect}, {63'd0, exp_now});
      if (exp_now) begin
        logic [63:0] r;
        r = exp_rd_q.pop_front();
        if (redirect) chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, r[31:0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] fpc, rpc, rtgt, ptgt;
    bit rv, rb, rt, pt;
    rst_n = 1'b0;
    fetch_valid = 0; fetch_pc = 0;
    res_valid = 0; res_is_branch = 0; res_pc = 0; res_taken = 0;
    res_target = 0; res_pred_taken = 0; res_pred_target = 0;
    model_reset();
    repeat (3) @(posedge clk);

    // cold lookup
    fetch_only(32'h100);
    // allocate on taken miss, then predict taken
    step(1, 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    fetch_only(32'h100);
    // saturate to strong-taken, then walk down
    repeat (3) step(1, 32'h100, 1, 1, 32'h100, 1, 32'h200, 1, 32'h200);
    step(1, 32'h100, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200);
    fetch_only(32'h100);
    step(1, 32'h100, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200);
    step(1, 32'h100, 1, 1, 32'h100, 0, 32'h0, 0, 32'h104);
    fetch_only(32'h100);
    // retrain, then alias 0x140 onto the same index
    repeat (2) step(1, 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    step(1, 32'h140, 1, 1, 32'h140, 1, 32'h300, 0, 32'h144);
    fetch_only(32'h100);
    fetch_only(32'h140);
    // not-taken mispredict with same-cycle lookup of the same index
    step(1, 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    fetch_only(32'h100);
    step(1, 32'h100, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200);
    fetch_only(32'h100);
    // non-branch resolution must be ignored
    step(1, 32'h100, 1, 0, 32'h100, 1, 32'h999, 0, 32'h0);
    step(1, 32'h180, 1, 0, 32'h180, 1, 32'h999, 0, 32'h0);
    fetch_only(32'h180);
    // fetch disabled, and address wrap on pc+4
    step(0, 32'h140, 0, 0, 0, 0, 0, 0, 0);
    fetch_only(32'hFFFF_FFFC);
    // back-to-back mispredicts
    step(1, 32'h200, 1, 1, 32'h200, 1, 32'h400, 0, 32'h204);
    step(1, 32'h204, 1, 1, 32'h204, 1, 32'h500, 0, 32'h208);
    step(1, 32'h200, 1, 1, 32'h208, 0, 32'h0, 1, 32'h600);
    // reset in the middle of a pending redirect pulse
    step(1, 32'h100, 1, 1, 32'h100, 1, 32'h700, 0, 32'h104);
    do_reset(2);
    fetch_only(32'h100);
    fetch_only(32'h140);
    fetch_only(32'h204);

    // randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 127) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        fpc  = 32'h100 + 32'($urandom_range(0, 31) << 2) + 32'($urandom_range(0, 3));
        rpc  = 32'h100 + 32'($urandom_range(0, 31) << 2) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) rpc = rpc | 32'h8000_0000;
        if ($urandom_range(0, 15) == 0) fpc = fpc | 32'h8000_0000;
        rtgt = 32'h1000 + 32'($urandom_range(0, 7) << 4);
        ptgt = $urandom_range(0, 1) ? rtgt : 32'h1000 + 32'($urandom_range(0, 7) << 4);
        rv   = ($urandom_range(0, 3) != 0);
        rb   = ($urandom_range(0, 7) != 0);
        rt   = $urandom_range(0, 1);
        pt   = $urandom_range(0, 1);
        step($urandom_range(0, 7) != 0, fpc, rv, rb, rpc, rt, rtgt, pt, ptgt);
      end
    end

    repeat (3) fetch_only(32'h100);
    @(negedge clk);
    #1;
    chk("redirects_drained", {32'd0, 32'(exp_rd_q.size())}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, meaning table depth; SHALL be a power of two, minimum 2.
REQ-002 Parameter XLEN, default 32, meaning address/PC width.
REQ-003 i_clk  input  1  meaning single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-005 i_fetch_valid  input  1  meaning fetch-stage lookup request.
REQ-006 i_fetch_pc  input  XLEN  meaning PC being fetched.
REQ-007 o_pred_taken  output  1  meaning predicted taken for i_fetch_pc.
REQ-008 o_pred_target  output  XLEN  meaning predicted target; i_fetch_pc+4 when not predicted taken.
REQ-009 i_res_valid  input  1  meaning execute-stage resolution valid this cycle.
REQ-010 i_res_is_branch  input  1  meaning resolved instruction is a conditional branch.
REQ-011 i_res_pc  input  XLEN  meaning PC of resolved instruction.
REQ-012 i_res_taken  input  1  meaning actual outcome, driven by the comparator branch flag.
REQ-013 i_res_target  input  XLEN  meaning actual taken target.
REQ-014 i_res_pred_taken / i_res_pred_target  input  1 / XLEN  meaning prediction carried down the pipeline with the instruction.
REQ-015 o_redirect  output  1  meaning one-cycle flush-and-redirect pulse.
REQ-016 o_redirect_pc  output  XLEN  meaning correct fetch PC accompanying o_redirect.
REQ-017 o_mispredict_cnt  output  16  meaning saturating mispredict count.

Function
REQ-018 Index SHALL be pc[log2(ENTRIES)+1:2]; tag SHALL be pc[XLEN-1:log2(ENTRIES)+2]; pc[1:0] ignored.
REQ-019 Each entry SHALL hold valid, tag, 2-bit counter, and XLEN target.
REQ-020 Lookup SHALL be combinational: hit = valid && tag match; o_pred_taken = i_fetch_valid && hit && counter[1]; o_pred_target = stored target if o_pred_taken, else i_fetch_pc+4 (mod 2^XLEN).
REQ-021 Counter encoding SHALL be 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-022 Update occurs only when i_res_valid && i_res_is_branch; otherwise table unchanged.
REQ-023 On update hit: counter increments if taken, decrements if not, saturating at 11/00; target overwritten with i_res_target only if taken.
REQ-024 On update miss and taken: entry allocated (overwrite), valid=1, tag from i_res_pc, counter=10, target=i_res_target.
REQ-025 On update miss and not taken: no allocation, table unchanged.
REQ-026 Mispredict = update condition && (i_res_taken != i_res_pred_taken || (i_res_taken && i_res_target != i_res_pred_target)).
REQ-027 On mispredict, o_redirect SHALL be 1 on the following cycle only, with o_redirect_pc = i_res_taken ? i_res_target : i_res_pc+4, registered.
REQ-028 Back-to-back mispredicts SHALL produce back-to-back pulses, each with its own PC.
REQ-029 o_mispredict_cnt SHALL increment by 1 per mispredict, registered, saturating at 0xFFFF.
REQ-030 Same-cycle lookup and update to same index: lookup SHALL return pre-update contents (no bypass).
REQ-031 i_res_valid with i_res_is_branch=0 SHALL cause no update, no redirect, no count change.

Reset
REQ-032 While i_rst_n=0: all valid=0, all counters=01, all targets=0, tags=0, o_redirect=0, o_redirect_pc=0, o_mispredict_cnt=0.
REQ-033 Reset asserted mid-operation SHALL immediately clear state, suppress any pending redirect pulse, and discard the concurrent update.
REQ-034 After reset, every lookup SHALL predict not-taken with target pc+4.

Verification
REQ-035 Cold lookup: reset, fetch pc=0x100 -> o_pred_taken=0, o_pred_target=0x104.
REQ-036 Allocate: resolve pc=0x100 taken target=0x200, pred_taken=0 -> next cycle o_redirect=1, o_redirect_pc=0x200, cnt=1; then fetch 0x100 -> taken, 0x200.
REQ-037 Saturation: three taken resolves at 0x100 then one not-taken -> counter 11 then 10, still predicts taken; two more not-taken -> 00, predicts not-taken, target 0x104.
REQ-038 Alias: after REQ-036, resolve pc=0x140 (same index, ENTRIES=16) taken target=0x300 -> entry replaced; fetch 0x100 -> not-taken.
REQ-039 Not-taken mispredict: resolve pc=0x100 taken=0, pred_taken=1 -> o_redirect_pc=0x104; same-cycle fetch 0x100 returns old prediction.
REQ-040 Reset mid-pulse: mispredict resolve, deassert i_rst_n next cycle -> o_redirect=0, cnt=0, all lookups not-taken.
